// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the registered priority-encoder queue.
// Optional round-robin arbitration is enabled by PRIO_ENC_ROUND_ROBIN_EN (see prio_enc_queue).
package prio_enc_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;
  localparam int MAX_WIDTH = 64;
  localparam int MAX_IDX_W = 6;

  function automatic int idx_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  // Returns a one-hot vector of up to MAX_WIDTH bits; out-of-range indices give zero.
  function automatic logic [MAX_WIDTH-1:0] onehot(input logic [MAX_IDX_W-1:0] idx,
                                                  input int width);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    if (int'(idx) < width) begin
      r[idx] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational find-first-set: searches mask downward from start, wrapping
// from bit 0 to bit WIDTH-1.
module prio_find
  import prio_enc_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [WIDTH-1:0] lo_sel;
  logic [WIDTH-1:0] hi_sel;
  logic             lo_found;
  logic             hi_found;
  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] hi_idx;

  // lo_sel covers start..0 (searched first), hi_sel covers WIDTH-1..start+1 (after wrap).
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_split
    assign lo_sel[gi] = mask[gi] && (IDX_W'(gi) <= start);
    assign hi_sel[gi] = mask[gi] && (IDX_W'(gi) > start);
  end

  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (lo_sel[k]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(k);
      end
      if (hi_sel[k]) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(k);
      end
    end
  end

  assign found = lo_found | hi_found;
  assign idx   = lo_found ? lo_idx : hi_idx;

endmodule

// File: rtl/prio_enc_queue.sv
// Registered priority-encoder queue: latches requests, grants one index per handshake.
// Define PRIO_ENC_ROUND_ROBIN_EN for round-robin search; default is fixed MSB-first priority.
module prio_enc_queue
  import prio_enc_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int CNT_W = DEF_CNT_W,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic             req_vld,
  input  logic             out_rdy,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] pending,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt
);

  logic             out_vld_reg,  out_vld_next;
  logic [IDX_W-1:0] out_idx_reg,  out_idx_next;
  logic [WIDTH-1:0] pending_reg,  pending_next;
  logic             overflow_reg, overflow_next;
  logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  logic             load;
  logic             grant;
  logic             found;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] search_start;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] set_mask;
  logic             dup;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last_grant_reg;

  assign search_start = (last_grant_reg == '0) ? IDX_W'(WIDTH - 1)
                                               : last_grant_reg - IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= '0;
    end else if (grant) begin
      last_grant_reg <= pick;
    end
  end
`else
  assign search_start = IDX_W'(WIDTH - 1);
`endif

  prio_find #(
    .WIDTH (WIDTH)
  ) u_find (
    .mask  (pending_reg),
    .start (search_start),
    .found (found),
    .idx   (pick)
  );

  assign load     = !out_vld_reg || out_rdy;
  assign grant    = load && found;
  assign clr_mask = grant ? WIDTH'(onehot(MAX_IDX_W'(pick), WIDTH)) : '0;
  assign set_mask = req_vld ? req_in : '0;
  // A bit being granted this edge is free to take a new request without counting as a drop.
  assign dup      = |(set_mask & pending_reg & ~clr_mask);

  always_comb begin
    out_vld_next  = out_vld_reg;
    out_idx_next  = out_idx_reg;
    pending_next  = (pending_reg & ~clr_mask) | set_mask;
    overflow_next = dup;
    drop_cnt_next = drop_cnt_reg;
    if (load) begin
      out_vld_next = found;
    end
    if (grant) begin
      out_idx_next = pick;
    end
    if (dup && (drop_cnt_reg != {CNT_W{1'b1}})) begin
      drop_cnt_next = drop_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_reg  <= 1'b0;
      out_idx_reg  <= '0;
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      out_vld_reg  <= out_vld_next;
      out_idx_reg  <= out_idx_next;
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign out_vld  = out_vld_reg;
  assign out_idx  = out_idx_reg;
  assign pending  = pending_reg;
  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_prio_enc_queue.sv
// Scoreboard bench for prio_enc_queue (WIDTH=8 and WIDTH=5 instances).
// Expected grant order follows PRIO_ENC_ROUND_ROBIN_EN when that macro is defined.
module tb_prio_enc_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] req_in_a;
  logic       req_vld_a, out_rdy_a, out_vld_a, overflow_a;
  logic [2:0] out_idx_a;
  logic [7:0] pending_a, drop_cnt_a;

  logic [4:0] req_in_b;
  logic       req_vld_b, out_rdy_b, out_vld_b, overflow_b;
  logic [2:0] out_idx_b;
  logic [4:0] pending_b;
  logic [3:0] drop_cnt_b;

  int checks = 0;
  int failures = 0;
  int exp_a[$];
  int exp_b[$];
  int e_a, e_b;

  prio_enc_queue #(.WIDTH(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .req_in(req_in_a), .req_vld(req_vld_a), .out_rdy(out_rdy_a),
    .out_vld(out_vld_a), .out_idx(out_idx_a), .pending(pending_a),
    .overflow(overflow_a), .drop_cnt(drop_cnt_a)
  );

  prio_enc_queue #(.WIDTH(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .req_in(req_in_b), .req_vld(req_vld_b), .out_rdy(out_rdy_b),
    .out_vld(out_vld_b), .out_idx(out_idx_b), .pending(pending_b),
    .overflow(overflow_b), .drop_cnt(drop_cnt_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted grant is popped from its scoreboard queue and compared.
  always @(negedge clk) begin
    if (!rst && out_vld_a && out_rdy_a) begin
      if (exp_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL grant_a_unexpected actual=%0d required=none", out_idx_a);
      end else begin
        e_a = exp_a.pop_front();
        $display("grant A idx=%0d expected=%0d", out_idx_a, e_a);
        chk("grant_a", 64'(out_idx_a), 64'(e_a));
      end
    end
    if (!rst && out_vld_b && out_rdy_b) begin
      if (exp_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL grant_b_unexpected actual=%0d required=none", out_idx_b);
      end else begin
        e_b = exp_b.pop_front();
        $display("grant B idx=%0d expected=%0d", out_idx_b, e_b);
        chk("grant_b", 64'(out_idx_b), 64'(e_b));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_in_a = 8'hFF; req_vld_a = 1'b1; out_rdy_a = 1'b0;
    req_in_b = 5'h1F; req_vld_b = 1'b1; out_rdy_b = 1'b0;

    // Reset held with requests active
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_vld", 64'(out_vld_a), 0);
      chk("rst_idx", 64'(out_idx_a), 0);
      chk("rst_pending", 64'(pending_a), 0);
      chk("rst_drop", 64'(drop_cnt_a), 0);
      chk("rst_overflow", 64'(overflow_a), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    req_vld_a = 1'b0; req_in_a = 8'h00;
    req_vld_b = 1'b0; req_in_b = 5'h00;
    tick(1);

    // Drain order
    out_rdy_a = 1'b1;
    req_in_a = 8'h29; req_vld_a = 1'b1;
    exp_a.push_back(5); exp_a.push_back(3); exp_a.push_back(0);
    tick(1);
    req_vld_a = 1'b0;
    chk("drain_pending", 64'(pending_a), 64'h29);
    chk("drain_vld0", 64'(out_vld_a), 0);
    tick(1); chk("drain_idx5", 64'(out_idx_a), 5); chk("drain_vld1", 64'(out_vld_a), 1);
    tick(1); chk("drain_idx3", 64'(out_idx_a), 3);
    tick(1); chk("drain_idx0", 64'(out_idx_a), 0);
    tick(1); chk("drain_end_vld", 64'(out_vld_a), 0); chk("drain_end_pend", 64'(pending_a), 0);

    // Backpressure
    out_rdy_a = 1'b0;
    req_in_a = 8'h29; req_vld_a = 1'b1;
    tick(1);
    req_vld_a = 1'b0;
    tick(1);
    chk("bp_idx", 64'(out_idx_a), 5); chk("bp_pending", 64'(pending_a), 64'h09);
    tick(3);
    chk("bp_hold_idx", 64'(out_idx_a), 5); chk("bp_hold_vld", 64'(out_vld_a), 1);
    chk("bp_hold_pending", 64'(pending_a), 64'h09);
    exp_a.push_back(5); exp_a.push_back(3); exp_a.push_back(0);
    out_rdy_a = 1'b1;
    tick(1); chk("bp_idx3", 64'(out_idx_a), 3);
    tick(1); chk("bp_idx0", 64'(out_idx_a), 0);
    tick(1); chk("bp_end_vld", 64'(out_vld_a), 0);

    // Overflow on a pending bit while the slot is held
    out_rdy_a = 1'b0;
    req_in_a = 8'h28; req_vld_a = 1'b1;
    tick(1);
    req_vld_a = 1'b0;
    tick(1);
    chk("ovf_pre", 64'(overflow_a), 0); chk("ovf_pend", 64'(pending_a), 64'h08);
    req_in_a = 8'h08; req_vld_a = 1'b1;
    tick(1);
    chk("ovf_pulse", 64'(overflow_a), 1); chk("ovf_drop1", 64'(drop_cnt_a), 1);
    req_vld_a = 1'b0;
    tick(1);
    chk("ovf_clear", 64'(overflow_a), 0); chk("ovf_drop_hold", 64'(drop_cnt_a), 1);

    // Re-arm: request on the bit granted this edge
    exp_a.push_back(5); exp_a.push_back(3); exp_a.push_back(3);
    out_rdy_a = 1'b1;
    req_in_a = 8'h08; req_vld_a = 1'b1;
    tick(1);
    req_vld_a = 1'b0;
    chk("rearm_idx", 64'(out_idx_a), 3); chk("rearm_ovf", 64'(overflow_a), 0);
    chk("rearm_pend", 64'(pending_a), 64'h08); chk("rearm_drop", 64'(drop_cnt_a), 1);
    tick(1); chk("rearm_idx2", 64'(out_idx_a), 3); chk("rearm_pend0", 64'(pending_a), 0);
    tick(1); chk("rearm_end_vld", 64'(out_vld_a), 0);

    // Drop counter saturation
    out_rdy_a = 1'b0;
    req_in_a = 8'h06; req_vld_a = 1'b1;
    tick(1);
    req_vld_a = 1'b0;
    tick(1);
    chk("sat_idx", 64'(out_idx_a), 2);
    req_in_a = 8'h02; req_vld_a = 1'b1;
    tick(300);
    chk("sat_drop", 64'(drop_cnt_a), 255); chk("sat_ovf", 64'(overflow_a), 1);
    req_vld_a = 1'b0;
    exp_a.push_back(2); exp_a.push_back(1);
    out_rdy_a = 1'b1;
    tick(3);
    chk("sat_end_vld", 64'(out_vld_a), 0); chk("sat_drop_hold", 64'(drop_cnt_a), 255);

    // Arbitration with two lines requesting every cycle
`ifdef PRIO_ENC_ROUND_ROBIN_EN
    for (int i = 0; i < 7; i++) exp_a.push_back((i % 2 == 0) ? 7 : 0);
`else
    for (int i = 0; i < 6; i++) exp_a.push_back(7);
    exp_a.push_back(0);
`endif
    req_in_a = 8'h81; req_vld_a = 1'b1;
    tick(6);
    req_vld_a = 1'b0;
    tick(4);
    chk("arb_end_vld", 64'(out_vld_a), 0); chk("arb_end_pend", 64'(pending_a), 0);

    // Non-power-of-two width
    out_rdy_b = 1'b1;
    req_in_b = 5'b1_0010; req_vld_b = 1'b1;
    exp_b.push_back(4); exp_b.push_back(1);
    tick(1);
    req_vld_b = 1'b0;
    chk("b_pending", 64'(pending_b), 64'h12);
    tick(1); chk("b_idx4", 64'(out_idx_b), 4);
    tick(1); chk("b_idx1", 64'(out_idx_b), 1);
    tick(1); chk("b_end_vld", 64'(out_vld_b), 0);

    // Reset asserted mid-cycle while a grant is held unaccepted
    out_rdy_b = 1'b0;
    req_in_b = 5'b0_0100; req_vld_b = 1'b1;
    tick(1);
    req_vld_b = 1'b0; req_in_b = 5'b0_1000; req_vld_b = 1'b1;
    tick(1);
    req_vld_b = 1'b0;
    chk("mrst_pre_vld", 64'(out_vld_b), 1); chk("mrst_pre_idx", 64'(out_idx_b), 2);
    chk("mrst_pre_pend", 64'(pending_b), 64'h08);
    #2 rst = 1'b1;
    #1;
    chk("mrst_async_vld", 64'(out_vld_b), 0); chk("mrst_async_pend", 64'(pending_b), 0);
    chk("mrst_async_idx", 64'(out_idx_b), 0);
    @(negedge clk);
    rst = 1'b0;
    out_rdy_b = 1'b1;
    tick(3);
    chk("mrst_no_replay", 64'(out_vld_b), 0);

    chk("queue_a_empty", 64'(exp_a.size()), 0);
    chk("queue_b_empty", 64'(exp_b.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
